// File: rtl/inst_fetcher_pkg.sv
// Shared widths, opcodes and types for the instruction fetcher.
// Build with BHT_EN defined to enable the dynamic branch predictor.
package inst_fetcher_pkg;

  localparam int InstWidth = 32;
  localparam int AddrWidth = 32;

  localparam logic [6:0] OPCODE_JAL  = 7'b1101111;
  localparam logic [6:0] OPCODE_B    = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR = 7'b1100111;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  typedef enum logic {
    IDLE,
    WAIT
  } fetch_state_t;

  typedef struct packed {
    logic [InstWidth-1:0] inst;
    logic [AddrWidth-1:0] pc;
    logic                 jump;
    logic [AddrWidth-1:0] pred_pc;
  } if_iq_t;

endpackage

// File: rtl/inst_fetcher_branch_predictor.sv
// Table of 2-bit saturating direction counters indexed by word PC.
// Only instantiated when the fetcher is built with BHT_EN.
module branch_predictor
  import inst_fetcher_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic [AddrWidth-1:0] lookup_pc,
  output logic                 lookup_taken,
  input  logic                 upd_en,
  input  logic [AddrWidth-1:0] upd_pc,
  input  logic                 upd_taken
);

  localparam int IdxW = $clog2(ENTRIES);

  logic [1:0]      bht [ENTRIES];
  logic [IdxW-1:0] lk_idx;
  logic [IdxW-1:0] up_idx;
  logic [1:0]      up_cnt;
  logic            unused_pc;

  assign lk_idx = lookup_pc[IdxW+1:2];
  assign up_idx = upd_pc[IdxW+1:2];
  assign up_cnt = bht[up_idx];

  assign lookup_taken = bht[lk_idx][1];

  assign unused_pc = ^{lookup_pc[AddrWidth-1:IdxW+2],
                       lookup_pc[1:0],
                       upd_pc[AddrWidth-1:IdxW+2],
                       upd_pc[1:0]};

  // lookup reads the pre-edge value when an update hits the same entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (rdy && upd_en) begin
      if (upd_taken) begin
        if (up_cnt != 2'b11) bht[up_idx] <= up_cnt + 2'd1;
      end else begin
        if (up_cnt != 2'b00) bht[up_idx] <= up_cnt - 2'd1;
      end
    end
  end

endmodule

// File: rtl/inst_fetcher.sv
// Fetch front end: one request in flight, next-PC prediction, queue push.
// BHT_EN selects counter-based branch direction; otherwise backward-taken.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int                   BHT_ENTRIES = 64,
  parameter logic [AddrWidth-1:0] RESET_PC    = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 IQ_is_full,
  output logic                 IF_output_valid,
  output logic [InstWidth-1:0] IF_inst,
  output logic [AddrWidth-1:0] IF_inst_pc,
  output logic                 IF_predicted_to_jump,
  output logic [AddrWidth-1:0] IF_predicted_pc,
  output logic                 MC_req_valid,
  output logic [AddrWidth-1:0] MC_req_addr,
  input  logic                 MC_resp_valid,
  input  logic [InstWidth-1:0] MC_resp_inst,
  input  logic                 ROB_roll_back_flag,
  input  logic [AddrWidth-1:0] ROB_target_pc,
  input  logic                 ROB_br_commit,
  input  logic [AddrWidth-1:0] ROB_br_pc,
  input  logic                 ROB_br_taken
);

  fetch_state_t         state;
  logic [AddrWidth-1:0] pc;
  logic                 discard;
  logic                 out_valid;
  if_iq_t               push;

  logic [6:0]           opcode;
  logic [AddrWidth-1:0] j_imm;
  logic [AddrWidth-1:0] b_imm;
  logic                 br_taken;
  logic                 pred_jump;
  logic [AddrWidth-1:0] pred_pc;

  assign opcode = MC_resp_inst[6:0];

  assign j_imm = {{11{MC_resp_inst[31]}}, MC_resp_inst[31],
                  MC_resp_inst[19:12], MC_resp_inst[20],
                  MC_resp_inst[30:21], 1'b0};

  assign b_imm = {{19{MC_resp_inst[31]}}, MC_resp_inst[31],
                  MC_resp_inst[7], MC_resp_inst[30:25],
                  MC_resp_inst[11:8], 1'b0};

`ifdef BHT_EN
  branch_predictor #(
    .ENTRIES(BHT_ENTRIES)
  ) u_bp (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .lookup_pc   (pc),
    .lookup_taken(br_taken),
    .upd_en      (ROB_br_commit),
    .upd_pc      (ROB_br_pc),
    .upd_taken   (ROB_br_taken)
  );
`else
  logic unused_br;
  assign unused_br = ^{ROB_br_commit, ROB_br_pc, ROB_br_taken};
  // backward branches are usually loops
  assign br_taken = b_imm[AddrWidth-1];
`endif

  always_comb begin
    pred_jump = False;
    pred_pc   = pc + 32'd4;
    unique case (1'b1)
      opcode == OPCODE_JAL: begin
        pred_jump = True;
        pred_pc   = pc + j_imm;
      end
      opcode == OPCODE_B: begin
        pred_jump = br_taken;
        pred_pc   = br_taken ? pc + b_imm : pc + 32'd4;
      end
      opcode == OPCODE_JALR: begin
        pred_jump = False;
      end
      default: begin
        pred_jump = False;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      discard   <= False;
      out_valid <= False;
      push      <= '0;
      MC_req_valid <= False;
      MC_req_addr  <= '0;
    end else if (rdy) begin
      out_valid <= False;
      unique case (state)
        IDLE: begin
          if (ROB_roll_back_flag) begin
            pc <= ROB_target_pc;
          end else if (!IQ_is_full) begin
            MC_req_valid <= True;
            MC_req_addr  <= pc;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (ROB_roll_back_flag) begin
            pc <= ROB_target_pc;
            if (MC_resp_valid) begin
              MC_req_valid <= False;
              discard      <= False;
              state        <= IDLE;
            end else begin
              discard <= True;
            end
          end else if (MC_resp_valid) begin
            MC_req_valid <= False;
            discard      <= False;
            state        <= IDLE;
            if (!discard) begin
              out_valid <= True;
              push      <= '{inst:    MC_resp_inst,
                             pc:      pc,
                             jump:    pred_jump,
                             pred_pc: pred_pc};
              pc        <= pred_pc;
            end
          end
        end
      endcase
    end
  end

  assign IF_output_valid      = out_valid;
  assign IF_inst              = push.inst;
  assign IF_inst_pc           = push.pc;
  assign IF_predicted_to_jump = push.jump;
  assign IF_predicted_pc      = push.pred_pc;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: fetch, predict, roll back, stall.
// Branch expectations follow the BHT_EN build setting.
module tb_inst_fetcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        IQ_is_full = 1'b0;
  logic        IF_output_valid;
  logic [31:0] IF_inst;
  logic [31:0] IF_inst_pc;
  logic        IF_predicted_to_jump;
  logic [31:0] IF_predicted_pc;
  logic        MC_req_valid;
  logic [31:0] MC_req_addr;
  logic        MC_resp_valid = 1'b0;
  logic [31:0] MC_resp_inst = '0;
  logic        ROB_roll_back_flag = 1'b0;
  logic [31:0] ROB_target_pc = '0;
  logic        ROB_br_commit = 1'b0;
  logic [31:0] ROB_br_pc = '0;
  logic        ROB_br_taken = 1'b0;

  localparam logic [31:0] ADDI   = 32'h0000_0013;
  localparam logic [31:0] JAL16  = 32'h0100_006F;
  localparam logic [31:0] BEQ_M8 = 32'hFE00_0CE3;
  localparam logic [31:0] BEQ_P8 = 32'h0000_0463;
  localparam logic [31:0] RET    = 32'h0000_8067;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  inst_fetcher dut (
    .clk                 (clk),
    .rst                 (rst),
    .rdy                 (rdy),
    .IQ_is_full          (IQ_is_full),
    .IF_output_valid     (IF_output_valid),
    .IF_inst             (IF_inst),
    .IF_inst_pc          (IF_inst_pc),
    .IF_predicted_to_jump(IF_predicted_to_jump),
    .IF_predicted_pc     (IF_predicted_pc),
    .MC_req_valid        (MC_req_valid),
    .MC_req_addr         (MC_req_addr),
    .MC_resp_valid       (MC_resp_valid),
    .MC_resp_inst        (MC_resp_inst),
    .ROB_roll_back_flag  (ROB_roll_back_flag),
    .ROB_target_pc       (ROB_target_pc),
    .ROB_br_commit       (ROB_br_commit),
    .ROB_br_pc           (ROB_br_pc),
    .ROB_br_taken        (ROB_br_taken)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] addr);
    for (int n = 0; n < 20 && !MC_req_valid; n++) tick();
    check({tag, "_req_valid"}, 32'(MC_req_valid), 32'd1);
    check({tag, "_req_addr"}, MC_req_addr, addr);
  endtask

  // returns right after the edge that captured the response
  task automatic fetch(input string tag,
                       input logic [31:0] addr,
                       input logic [31:0] inst,
                       input logic        jump,
                       input logic [31:0] pred);
    wait_req(tag, addr);
    tick();
    tick();
    MC_resp_valid = 1'b1;
    MC_resp_inst  = inst;
    tick();
    MC_resp_valid = 1'b0;
    check({tag, "_push"}, 32'(IF_output_valid), 32'd1);
    check({tag, "_inst"}, IF_inst, inst);
    check({tag, "_pc"}, IF_inst_pc, addr);
    check({tag, "_jump"}, 32'(IF_predicted_to_jump), 32'(jump));
    check({tag, "_pred"}, IF_predicted_pc, pred);
    check({tag, "_req_drop"}, 32'(MC_req_valid), 32'd0);
  endtask

  logic        beq_jump;
  logic [31:0] beq_pred;
  int          seen;

  initial begin
`ifdef BHT_EN
    beq_jump = 1'b0;
    beq_pred = 32'h24;
`else
    beq_jump = 1'b1;
    beq_pred = 32'h18;
`endif
    tick();
    tick();
    tick();
    check("rst_req_valid", 32'(MC_req_valid), 32'd0);
    check("rst_push", 32'(IF_output_valid), 32'd0);
    check("rst_pred_pc", IF_predicted_pc, 32'd0);
    rst = 1'b0;

    fetch("addi0", 32'h0, ADDI, 1'b0, 32'h4);
    tick();
    check("push_one_cycle", 32'(IF_output_valid), 32'd0);
    fetch("addi4", 32'h4, ADDI, 1'b0, 32'h8);
    fetch("jal", 32'h8, JAL16, 1'b1, 32'h18);
    fetch("beq_fwd", 32'h18, BEQ_P8, 1'b0, 32'h1C);
    fetch("addi1c", 32'h1C, ADDI, 1'b0, 32'h20);
    fetch("beq_back", 32'h20, BEQ_M8, beq_jump, beq_pred);

    // roll back while waiting; late response must be dropped
    wait_req("rb", beq_pred);
    ROB_roll_back_flag = 1'b1;
    ROB_target_pc      = 32'h100;
    tick();
    ROB_roll_back_flag = 1'b0;
    check("rb_req_held", 32'(MC_req_valid), 32'd1);
    tick();
    MC_resp_valid = 1'b1;
    MC_resp_inst  = ADDI;
    tick();
    MC_resp_valid = 1'b0;
    check("rb_no_push", 32'(IF_output_valid), 32'd0);
    fetch("rb_tgt", 32'h100, ADDI, 1'b0, 32'h104);

    // queue full holds off requests
    IQ_is_full = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (MC_req_valid) seen++;
    end
    check("full_no_req", 32'(seen), 32'd0);
    IQ_is_full = 1'b0;
    tick();
    check("full_rel_req", 32'(MC_req_valid), 32'd1);
    check("full_rel_addr", MC_req_addr, 32'h104);

    // freeze with response pending
    tick();
    tick();
    MC_resp_valid = 1'b1;
    MC_resp_inst  = RET;
    rdy = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (IF_output_valid || !MC_req_valid || MC_req_addr != 32'h104) seen++;
    end
    check("rdy_frozen", 32'(seen), 32'd0);
    rdy = 1'b1;
    tick();
    MC_resp_valid = 1'b0;
    check("rdy_push", 32'(IF_output_valid), 32'd1);
    check("rdy_pc", IF_inst_pc, 32'h104);
    check("jalr_jump", 32'(IF_predicted_to_jump), 32'd0);
    check("jalr_pred", IF_predicted_pc, 32'h108);

    // train 0x20 taken twice, then refetch it via roll back
    ROB_br_commit = 1'b1;
    ROB_br_pc     = 32'h20;
    ROB_br_taken  = 1'b1;
    tick();
    check("rdy_single_push", 32'(IF_output_valid), 32'd0);
    check("req_108", MC_req_addr, 32'h108);
    tick();
    ROB_br_commit      = 1'b0;
    ROB_roll_back_flag = 1'b1;
    ROB_target_pc      = 32'h20;
    tick();
    ROB_roll_back_flag = 1'b0;
    MC_resp_valid = 1'b1;
    MC_resp_inst  = ADDI;
    tick();
    MC_resp_valid = 1'b0;
    check("rb2_no_push", 32'(IF_output_valid), 32'd0);
    fetch("beq_trained", 32'h20, BEQ_M8, 1'b1, 32'h18);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
